// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store stage driving a word-wide data bus with byte enables.
// Optional MISALIGN_TRAP_EN: non-naturally-aligned accesses complete with an error and no bus beat.
module load_store_unit #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  whb_i,
  input  logic        su_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    whb_q, whb_d;
  logic          su_q, su_d;
  logic          err_q, err_d;
  logic          mem_req_q, mem_req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rbuf0_q, rbuf0_d;
  logic [31:0]   rbuf1_q, rbuf1_d;

  logic [1:0]    off;
  logic [3:0]    size_mask;
  logic [7:0]    be64;
  logic [63:0]   wd64;
  logic          split;
  logic [31:0]   beat_addr0, beat_addr1;
  logic [31:0]   rsh;
  logic          in_bad;
  logic          ack_ok;
  logic          timeout_hit;
  logic [CW-1:0] cnt_inc;

  // Access geometry: the 8-lane view spans the addressed word and the next one.
  always_comb begin
    off = addr_q[1:0];
    case (whb_q)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    be64       = {4'b0000, size_mask} << off;
    wd64       = {32'b0, wdata_q} << {off, 3'b000};
    split      = |be64[7:4];
    beat_addr0 = {addr_q[31:2], 2'b00};
    beat_addr1 = beat_addr0 + 32'd4;
    rsh        = 32'({rbuf1_q, rbuf0_q} >> {off, 3'b000});
  end

  always_comb begin
    in_bad = (whb_i == 2'b11);
`ifdef MISALIGN_TRAP_EN
    if ((whb_i == 2'b01 && addr_i[0]) || (whb_i == 2'b10 && addr_i[1:0] != 2'b00))
      in_bad = 1'b1;
`else
`endif
  end

  always_comb begin
    ack_ok      = mem_req_q && mem_ack_i;
    cnt_inc     = cnt_q + CW'(1);
    timeout_hit = (ACK_TIMEOUT != 0) && mem_req_q && !mem_ack_i &&
                  (cnt_inc == CW'(ACK_TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      whb_q     <= '0;
      su_q      <= 1'b0;
      err_q     <= 1'b0;
      mem_req_q <= 1'b0;
      cnt_q     <= '0;
      rbuf0_q   <= '0;
      rbuf1_q   <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      whb_q     <= whb_d;
      su_q      <= su_d;
      err_q     <= err_d;
      mem_req_q <= mem_req_d;
      cnt_q     <= cnt_d;
      rbuf0_q   <= rbuf0_d;
      rbuf1_q   <= rbuf1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_i) state_d = in_bad ? RESP : BEAT0;
      BEAT0: begin
        if (ack_ok)           state_d = split ? BEAT1 : RESP;
        else if (timeout_hit) state_d = RESP;
      end
      BEAT1: if (ack_ok || timeout_hit) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and bus-request register; the request drops on the cycle after ack/timeout.
  always_comb begin
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    whb_d     = whb_q;
    su_d      = su_q;
    err_d     = err_q;
    mem_req_d = mem_req_q;
    cnt_d     = cnt_q;
    rbuf0_d   = rbuf0_q;
    rbuf1_d   = rbuf1_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d      = we_i;
          addr_d    = addr_i;
          wdata_d   = wdata_i;
          whb_d     = whb_i;
          su_d      = su_i;
          err_d     = in_bad;
          mem_req_d = !in_bad;
          cnt_d     = '0;
          rbuf0_d   = '0;
          rbuf1_d   = '0;
        end
      end
      BEAT0: begin
        if (ack_ok) begin
          rbuf0_d   = mem_rdata_i;
          mem_req_d = 1'b0;
          cnt_d     = '0;
        end else if (timeout_hit) begin
          err_d     = 1'b1;
          mem_req_d = 1'b0;
        end else if (mem_req_q) begin
          cnt_d     = cnt_inc;
        end
      end
      BEAT1: begin
        // First BEAT1 cycle is the idle bus gap after the first beat's ack.
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
          cnt_d     = '0;
        end else if (ack_ok) begin
          rbuf1_d   = mem_rdata_i;
          mem_req_d = 1'b0;
        end else if (timeout_hit) begin
          err_d     = 1'b1;
          mem_req_d = 1'b0;
        end else begin
          cnt_d     = cnt_inc;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != IDLE);
    done_o      = (state_q == RESP);
    err_o       = (state_q == RESP) && err_q;
    mem_req_o   = mem_req_q;
    mem_we_o    = mem_req_q && we_q;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (mem_req_q) begin
      if (state_q == BEAT1) begin
        mem_addr_o  = beat_addr1;
        mem_be_o    = be64[7:4];
        mem_wdata_o = wd64[63:32];
      end else begin
        mem_addr_o  = beat_addr0;
        mem_be_o    = be64[3:0];
        mem_wdata_o = wd64[31:0];
      end
    end
    rdata_o = '0;
    if (state_q == RESP && !err_q && !we_q) begin
      case (whb_q)
        2'b00:   rdata_o = {{24{su_q & rsh[7]}}, rsh[7:0]};
        2'b01:   rdata_o = {{16{su_q & rsh[15]}}, rsh[15:0]};
        default: rdata_o = rsh;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with directed vectors.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [1:0]  whb_i = '0;
  logic        su_i = 1'b0;
  logic        busy_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  load_store_unit #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .whb_i(whb_i), .su_i(su_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} beat_t;
  typedef struct {logic err; logic [31:0] rdata; int cyc;} resp_t;
  typedef struct {string name; logic [31:0] act; logic [31:0] exp;} chk_t;

  beat_t beat_q[$];
  resp_t resp_q[$];
  chk_t  chk_q[$];
  int    errors = 0;
  int    checks = 0;
  int    req_cycles = 0;

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: the only process that compares and steps the counters.
  always @(negedge clk) begin
    chk_t  c;
    beat_t b;
    resp_t r;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      cmp(c.name, c.act, c.exp);
    end
    if (rst_n) begin
      if (mem_req_o) req_cycles++;
      if (mem_req_o && mem_ack_i) begin
        if (beat_q.size() == 0) cmp("unexpected_beat", 32'd1, 32'd0);
        else begin
          b = beat_q.pop_front();
          cmp("beat_we", {31'b0, mem_we_o}, {31'b0, b.we});
          cmp("beat_addr", mem_addr_o, b.addr);
          cmp("beat_be", {28'b0, mem_be_o}, {28'b0, b.be});
          cmp("beat_wdata", mem_wdata_o, b.wdata);
        end
      end
      if (done_o) begin
        if (resp_q.size() == 0) cmp("unexpected_done", 32'd1, 32'd0);
        else begin
          r = resp_q.pop_front();
          cmp("resp_err", {31'b0, err_o}, {31'b0, r.err});
          cmp("resp_rdata", rdata_o, r.rdata);
          cmp("resp_cycle", cyc, r.cyc);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    chk_t c;
    c.name = n; c.act = a; c.exp = e;
    chk_q.push_back(c);
  endtask

  task automatic exp_beat(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    beat_t b;
    b.we = we; b.addr = a; b.be = be; b.wdata = wd;
    beat_q.push_back(b);
  endtask

  task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] whb, input logic su, input int nbeats,
                     input logic [31:0] rd0, input logic [31:0] rd1, input int delay,
                     input logic eerr, input logic [31:0] erd, input int lat, input int ereq);
    resp_t r;
    int req0;
    int waitc;
    @(posedge clk); #1;
    r.err = eerr; r.rdata = erd; r.cyc = cyc + lat;
    resp_q.push_back(r);
    req0 = req_cycles;
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; whb_i = whb; su_i = su;
    @(posedge clk); #1;
    req_i = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      waitc = 0;
      while (!mem_req_o && waitc < 50) begin
        @(posedge clk); #1;
        waitc++;
      end
      if (!mem_req_o) chk("beat_wait", 32'd0, 32'd1);
      else begin
        repeat (delay) begin
          @(posedge clk); #1;
        end
        mem_ack_i = 1'b1;
        mem_rdata_i = (b == 0) ? rd0 : rd1;
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
      end
    end
    waitc = 0;
    while (busy_o && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk("busy_release", {31'b0, busy_o}, 32'd0);
    chk("req_cycles", req_cycles - req0, ereq);
  endtask

  initial begin
    int start;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy_done_err", {29'b0, busy_o, done_o, err_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_mem_ctrl", {26'b0, mem_req_o, mem_we_o, mem_be_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    rst_n = 1'b1;

    exp_beat(1'b0, 32'h100, 4'b1111, 32'h0);
    run(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 1, 32'hDEADBEEF, 32'h0, 0, 1'b0, 32'hDEADBEEF, 2, 1);

    exp_beat(1'b0, 32'h100, 4'b1000, 32'h0);
    run(1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 1, 32'h80123456, 32'h0, 0, 1'b0, 32'hFFFFFF80, 2, 1);
    exp_beat(1'b0, 32'h100, 4'b1000, 32'h0);
    run(1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 1, 32'h80123456, 32'h0, 0, 1'b0, 32'h00000080, 2, 1);

    exp_beat(1'b1, 32'h200, 4'b1100, 32'hABCD0000);
    run(1'b1, 32'h202, 32'h1234ABCD, 2'b01, 1'b0, 1, 32'h0, 32'h0, 0, 1'b0, 32'h0, 2, 1);

    exp_beat(1'b0, 32'h100, 4'b1100, 32'h0);
    run(1'b0, 32'h102, 32'h0, 2'b01, 1'b1, 1, 32'h80011234, 32'h0, 1, 1'b0, 32'hFFFF8001, 3, 2);

`ifdef MISALIGN_TRAP_EN
    run(1'b0, 32'h1FE, 32'h0, 2'b10, 1'b0, 0, 32'h0, 32'h0, 0, 1'b1, 32'h0, 1, 0);
    run(1'b1, 32'hFFFFFFFF, 32'h11223344, 2'b10, 1'b0, 0, 32'h0, 32'h0, 0, 1'b1, 32'h0, 1, 0);
    run(1'b0, 32'h001, 32'h0, 2'b01, 1'b0, 0, 32'h0, 32'h0, 0, 1'b1, 32'h0, 1, 0);
`else
    exp_beat(1'b0, 32'h1FC, 4'b1100, 32'h0);
    exp_beat(1'b0, 32'h200, 4'b0011, 32'h0);
    run(1'b0, 32'h1FE, 32'h0, 2'b10, 1'b0, 2, 32'hBBAA0000, 32'h0000DDCC, 0, 1'b0, 32'hDDCCBBAA, 4, 2);
    exp_beat(1'b1, 32'hFFFFFFFC, 4'b1000, 32'h44000000);
    exp_beat(1'b1, 32'h00000000, 4'b0111, 32'h00112233);
    run(1'b1, 32'hFFFFFFFF, 32'h11223344, 2'b10, 1'b0, 2, 32'h0, 32'h0, 0, 1'b0, 32'h0, 4, 2);
    exp_beat(1'b0, 32'h000, 4'b0110, 32'h0);
    run(1'b0, 32'h001, 32'h0, 2'b01, 1'b0, 1, 32'h00ABCD00, 32'h0, 2, 1'b0, 32'h0000ABCD, 4, 3);
`endif

    run(1'b0, 32'h300, 32'h0, 2'b10, 1'b0, 0, 32'h0, 32'h0, 0, 1'b1, 32'h0, 5, 4);
    run(1'b0, 32'h300, 32'h0, 2'b11, 1'b0, 0, 32'h0, 32'h0, 0, 1'b1, 32'h0, 1, 0);

    // Reset asserted while the first beat is outstanding.
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h100; whb_i = 2'b10; su_i = 1'b0;
    @(posedge clk); #1;
    req_i = 1'b0;
    chk("req_before_rst", {31'b0, mem_req_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_busy", {30'b0, mem_req_o, busy_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle", {31'b0, busy_o}, 32'd0);

    // A second request presented during BEAT0 must not disturb the first access.
    @(posedge clk); #1;
    start = cyc;
    begin
      resp_t r;
      r.err = 1'b0; r.rdata = 32'h01020304; r.cyc = start + 2;
      resp_q.push_back(r);
    end
    exp_beat(1'b0, 32'h100, 4'b1111, 32'h0);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h100; wdata_i = 32'h0; whb_i = 2'b10; su_i = 1'b0;
    @(posedge clk); #1;
    addr_i = 32'h305; whb_i = 2'b00; we_i = 1'b1; wdata_i = 32'hFFFFFFFF;
    chk("busy_in_beat0", {31'b0, busy_o}, 32'd1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h01020304;
    @(posedge clk); #1;
    mem_ack_i = 1'b0; req_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ignored_req_idle", {31'b0, busy_o}, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("resp_q_drained", resp_q.size(), 32'd0);
    chk("beat_q_drained", beat_q.size(), 32'd0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
